// File: rtl/ctrl_fsm_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the FSM state codes, the instruction class codes seen on `op`, and
// the encodings of the datapath mux selects driven by the controller.
package ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_EXEC_I = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  // Instruction classes; 3'b101 and 3'b110 are executed as NOPs.
  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_I    = 3'b001;
  localparam logic [2:0] OP_MEM  = 3'b010;
  localparam logic [2:0] OP_BR   = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  // result_src
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // alu_src_a
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS    = 2'b10;

  // alu_src_b
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // imm_src
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;

  // States whose exit to FETCH completes (retires) an instruction.
  function automatic logic retires(input state_t s);
    return s inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP};
  endfunction

endpackage

// File: rtl/ctrl_instret_counter.sv
// Retired-instruction counter, free-running and wrapping at 2^CNT_W.
// Ports: clk, reset (sync, active-low), en (count this edge), count.
module ctrl_instret_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (en)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit: Moore FSM sequencing fetch, decode, execute,
// memory access and writeback, driving datapath selects and write enables.
// Optional macro CTRL_INSTRET_EN adds the `instret` retired-instruction count.
// Ports:
//   clk, reset (sync, active-low)
//   zero, op, funct3, mem_ready      : decode fields and status inputs
//   mem_req, pc_write, adr_src, mem_write, ir_write, reg_write
//   result_src, alu_control, alu_src_a, alu_src_b, imm_src
//   state_o (debug state code), zflag (registered zero), halted
//   instret (only with CTRL_INSTRET_EN)
module multicycle_ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int ALUC_W  = 3,
  parameter int STATE_W = 4,
  parameter int MEM_HS  = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               zero,
  input  logic [2:0]         op,
  input  logic [2:0]         funct3,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [ALUC_W-1:0]  alu_control,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [STATE_W-1:0] state_o,
  output logic               zflag,
  output logic               halted
`ifdef CTRL_INSTRET_EN
  ,
  output logic [CNT_W-1:0]   instret
`endif
);

  state_t state, state_next;
  logic   ready;

  // Without the handshake every memory access completes in one cycle.
  assign ready = (MEM_HS != 0) ? mem_ready : 1'b1;

  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_R:    state_next = S_EXEC_R;
          OP_I:    state_next = S_EXEC_I;
          OP_MEM:  state_next = S_MEMADR;
          OP_BR:   state_next = S_BRANCH;
          OP_JMP:  state_next = S_JUMP;
          OP_HALT: state_next = S_HALT;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = funct3[0] ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next = ready ? S_FETCH : S_MEMWR;
      S_EXEC_R,
      S_EXEC_I: state_next = S_ALUWB;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state <= S_FETCH;
      zflag <= 1'b0;
    end else begin
      state <= state_next;
      // Every EXEC state lasts one cycle, so this is the edge leaving it.
      if (state == S_EXEC_R || state == S_EXEC_I)
        zflag <= zero;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_control = '0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_REG;
    imm_src     = IMM_I;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        ir_write   = ready;
        pc_write   = ready;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_S;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = ready;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_DATA;
      end
      S_EXEC_R: begin
        alu_src_a   = SRCA_RS;
        alu_src_b   = SRCB_REG;
        alu_control = ALUC_W'(funct3);
      end
      S_EXEC_I: begin
        alu_src_a   = SRCA_RS;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_I;
        alu_control = ALUC_W'(funct3);
      end
      S_ALUWB: begin
        reg_write   = 1'b1;
        result_src  = RES_ALUOUT;
        alu_control = ALUC_W'(funct3);
      end
      S_BRANCH, S_JUMP: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_B;
        result_src = RES_ALU;
        // funct3[0] = 0 keeps the legacy branch-if-not-zero polarity.
        if (state == S_JUMP)
          pc_write = 1'b1;
        else
          pc_write = funct3[0] ? zflag : ~zflag;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
    // Reset is synchronous, so the state may still be mid-access while it is
    // held low; suppress every side effect until the FETCH edge lands.
    if (!reset) begin
      mem_req   = 1'b0;
      pc_write  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state_o = STATE_W'(state);

`ifdef CTRL_INSTRET_EN
  logic retire;

  assign retire = retires(state) && (state_next == S_FETCH);

  ctrl_instret_counter #(
    .CNT_W(CNT_W)
  ) u_instret (
    .clk   (clk),
    .reset (reset),
    .en    (retire),
    .count (instret)
  );
`endif

endmodule
